// File: rtl/mixer_scheduler.sv
// mixer_scheduler: gathers serial ADC samples into 4-lane frames and tags each lane with its NCO phase
module mixer_scheduler #(
  parameter int SAMPLE_W = 12,
  parameter int PHASE_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [SAMPLE_W-1:0] s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic                flush_i,
  input  logic [PHASE_W-1:0]  fcw_i,
  input  logic                fcw_load_i,
  output logic [SAMPLE_W-1:0] sample0_o,
  output logic [SAMPLE_W-1:0] sample1_o,
  output logic [SAMPLE_W-1:0] sample2_o,
  output logic [SAMPLE_W-1:0] sample3_o,
  output logic [PHASE_W-1:0]  phase0_o,
  output logic [PHASE_W-1:0]  phase1_o,
  output logic [PHASE_W-1:0]  phase2_o,
  output logic [PHASE_W-1:0]  phase3_o,
  output logic [3:0]          valid_o,
  output logic [15:0]         frame_cnt_o
);
  typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;
  state_t state, nxt;
  logic [1:0] cnt;
  logic [2:0] n;
  logic accept, emit;
  logic [3:0] mask;
  logic [PHASE_W-1:0] acc, fcw_act, pend, pend_nxt, fcw_eff;
  logic [SAMPLE_W-1:0] lane [4];
  logic [SAMPLE_W-1:0] samp [4];
  logic [PHASE_W-1:0] ph [4];
  always_ff @(posedge clk_i)
    state <= rst_i ? IDLE : nxt;
  always_comb begin
    nxt = state == IDLE ? (enable_i ? FILL : IDLE)
        : state == EMIT ? (enable_i ? FILL : IDLE)
        : !enable_i ? (cnt != 2'd0 ? EMIT : IDLE)
        : (n == 3'd4 || (flush_i && n != 3'd0)) ? EMIT : FILL;
  end
  always_comb begin
    s_ready_o = state == FILL && enable_i;
    accept = s_ready_o && s_valid_i;
    n = {1'b0, cnt} + {2'b0, accept};
    emit = state == FILL && nxt == EMIT;
    mask = n == 3'd4 ? 4'b1111 : n == 3'd3 ? 4'b0111 : n == 3'd2 ? 4'b0011 : 4'b0001;
    pend_nxt = fcw_load_i ? fcw_i : pend;
    fcw_eff = cnt == 2'd0 ? pend_nxt : fcw_act;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= 2'd0;
      acc <= '0;
      fcw_act <= '0;
      pend <= '0;
      valid_o <= 4'b0;
      frame_cnt_o <= 16'd0;
      for (int k = 0; k < 4; k++) begin
        lane[k] <= '0;
        samp[k] <= '0;
        ph[k] <= '0;
      end
    end else begin
      pend <= pend_nxt;
      fcw_act <= fcw_eff;
      valid_o <= emit ? mask : 4'b0;
      cnt <= emit ? 2'd0 : cnt + 2'(accept);
      if (accept)
        lane[cnt] <= s_data_i;
      if (emit) begin
        acc <= acc + fcw_eff * PHASE_W'(n);
        frame_cnt_o <= frame_cnt_o + 16'd1;
        for (int k = 0; k < 4; k++) begin
          samp[k] <= (accept && cnt == 2'(k)) ? s_data_i : lane[k];
          ph[k] <= acc + fcw_eff * PHASE_W'(k);
        end
      end
    end
  end
  assign sample0_o = samp[0];
  assign sample1_o = samp[1];
  assign sample2_o = samp[2];
  assign sample3_o = samp[3];
  assign phase0_o = ph[0];
  assign phase1_o = ph[1];
  assign phase2_o = ph[2];
  assign phase3_o = ph[3];
endmodule

// File: tb/tb_mixer_scheduler.sv
// tb_mixer_scheduler: scoreboard bench for mixer_scheduler with hand-computed frame expectations
module tb_mixer_scheduler;
  logic clk = 0, rst_i = 0, enable_i = 0, s_valid_i = 0, s_ready_o, flush_i = 0, fcw_load_i = 0;
  logic [11:0] s_data_i = 0, sample0_o, sample1_o, sample2_o, sample3_o;
  logic [31:0] fcw_i = 0, phase0_o, phase1_o, phase2_o, phase3_o;
  logic [3:0] valid_o;
  logic [15:0] frame_cnt_o;
  int total = 0, passed = 0, stalls;
  typedef struct packed {
    logic [3:0] v;
    logic [3:0][11:0] s;
    logic [3:0][31:0] p;
    logic [15:0] fc;
  } exp_t;
  exp_t q[$];
  exp_t e_m;
  logic [11:0] so [4];
  logic [31:0] po [4];
  always #5 clk = ~clk;
  mixer_scheduler dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o), .flush_i(flush_i), .fcw_i(fcw_i), .fcw_load_i(fcw_load_i),
    .sample0_o(sample0_o), .sample1_o(sample1_o), .sample2_o(sample2_o), .sample3_o(sample3_o),
    .phase0_o(phase0_o), .phase1_o(phase1_o), .phase2_o(phase2_o), .phase3_o(phase3_o),
    .valid_o(valid_o), .frame_cnt_o(frame_cnt_o)
  );
  assign so[0] = sample0_o;
  assign so[1] = sample1_o;
  assign so[2] = sample2_o;
  assign so[3] = sample3_o;
  assign po[0] = phase0_o;
  assign po[1] = phase1_o;
  assign po[2] = phase2_o;
  assign po[3] = phase3_o;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask
  task automatic push_exp(input logic [3:0] v, input logic [11:0] s0, s1, s2, s3,
                          input logic [31:0] p0, p1, p2, p3, input logic [15:0] fc);
    exp_t e;
    e.v = v;
    e.s = {s3, s2, s1, s0};
    e.p = {p3, p2, p1, p0};
    e.fc = fc;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (valid_o != 4'b0) begin
      if (q.size() == 0) check("unexpected_valid", {28'b0, valid_o}, 32'd0);
      else begin
        e_m = q.pop_front();
        check("valid", {28'b0, valid_o}, {28'b0, e_m.v});
        check("frame_cnt", {16'b0, frame_cnt_o}, {16'b0, e_m.fc});
        for (int k = 0; k < 4; k++)
          if (e_m.v[k]) begin
            check($sformatf("sample%0d", k), {20'b0, so[k]}, {20'b0, e_m.s[k]});
            check($sformatf("phase%0d", k), po[k], e_m.p[k]);
          end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_i = 1;
    tick();
    rst_i = 0;
  endtask
  task automatic load(input logic [31:0] v);
    fcw_i = v;
    fcw_load_i = 1;
    tick();
    fcw_load_i = 0;
  endtask
  task automatic wait_ready(input bit count_stalls);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (s_ready_o) ok = 1;
      else if (count_stalls) stalls++;
    end
    check("accept", {31'b0, ok}, 32'd1);
    tick();
  endtask
  task automatic send(input logic [11:0] d);
    s_data_i = d;
    s_valid_i = 1;
    wait_ready(0);
    s_valid_i = 0;
  endtask
  task automatic check_zero(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, {28'b0, valid_o}, 32'd0);
    check({tag, "_sample0"}, {20'b0, sample0_o}, 32'd0);
    check({tag, "_sample3"}, {20'b0, sample3_o}, 32'd0);
    check({tag, "_phase0"}, phase0_o, 32'd0);
    check({tag, "_phase3"}, phase3_o, 32'd0);
    check({tag, "_frame_cnt"}, {16'b0, frame_cnt_o}, 32'd0);
    check({tag, "_ready"}, {31'b0, s_ready_o}, 32'd0);
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    check_zero("reset");
    load(32'h1000_0000);
    enable_i = 1;
    push_exp(4'b1111, 1, 2, 3, 4, 32'h0, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 1);
    push_exp(4'b1111, 5, 6, 7, 8, 32'h4000_0000, 32'h5000_0000, 32'h6000_0000, 32'h7000_0000, 2);
    for (int i = 1; i <= 8; i++) send(12'(i));
    repeat (2) tick();
    do_reset();
    load(32'h4000_0000);
    push_exp(4'b1111, 11, 12, 13, 14, 32'h0, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 1);
    push_exp(4'b1111, 15, 16, 17, 18, 32'h0, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 2);
    for (int i = 11; i <= 18; i++) send(12'(i));
    repeat (2) tick();
    do_reset();
    load(32'h100);
    push_exp(4'b0011, 9, 10, 0, 0, 32'h0, 32'h100, 32'h0, 32'h0, 1);
    push_exp(4'b1111, 1, 2, 3, 4, 32'h200, 32'h300, 32'h400, 32'h500, 2);
    send(9);
    send(10);
    flush_i = 1;
    tick();
    flush_i = 0;
    for (int i = 1; i <= 4; i++) send(12'(i));
    repeat (2) tick();
    do_reset();
    load(32'h100);
    push_exp(4'b1111, 1, 2, 3, 4, 32'h0, 32'h100, 32'h200, 32'h300, 1);
    push_exp(4'b1111, 5, 6, 7, 8, 32'h400, 32'h600, 32'h800, 32'hA00, 2);
    send(1);
    send(2);
    load(32'h200);
    for (int i = 3; i <= 8; i++) send(12'(i));
    repeat (2) tick();
    send(31);
    send(32);
    send(33);
    do_reset();
    check_zero("midreset");
    load(32'h1000);
    push_exp(4'b1111, 1, 2, 3, 4, 32'h0, 32'h1000, 32'h2000, 32'h3000, 1);
    push_exp(4'b0111, 21, 22, 23, 0, 32'h4000, 32'h5000, 32'h6000, 32'h0, 2);
    for (int i = 1; i <= 4; i++) send(12'(i));
    send(21);
    send(22);
    send(23);
    enable_i = 0;
    repeat (3) tick();
    enable_i = 1;
    do_reset();
    load(32'h10);
    for (int f = 0; f < 3; f++)
      push_exp(4'b1111, 12'(100 + 4 * f), 12'(101 + 4 * f), 12'(102 + 4 * f), 12'(103 + 4 * f),
               32'(64 * f), 32'(64 * f + 16), 32'(64 * f + 32), 32'(64 * f + 48), 16'(f + 1));
    stalls = 0;
    s_valid_i = 1;
    for (int i = 0; i < 12; i++) begin
      s_data_i = 12'(100 + i);
      wait_ready(i > 0);
    end
    s_valid_i = 0;
    check("stalls", 32'(stalls), 32'd2);
    repeat (3) tick();
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
